// File: rtl/ts_pkt_scheduler.sv
// ts_pkt_scheduler: packet-level round-robin scheduler muxing CHN_NUM TS byte streams onto one registered output
// Ports:
//   clk, rst_n            clock, async active-low reset
//   chn_rdy               per-channel "full packet buffered" request
//   chn_valid/data/eop    per-channel byte stream, channel i in chn_data[8i+7:8i]
//   chn_ack               one-hot grant held for the whole packet
//   dn_afull              downstream almost-full, blocks the next arbitration only
//   out_valid/data/eop    registered byte stream of the granted channel
//   cur_chn, busy         granted channel index, valid while busy
//   timeout_err           one-cycle pulse on watchdog release
//   len_err               one-cycle pulse on bad packet length (TS_PKT_LEN_CHECK_EN), else 0
// Optional: define TS_PKT_LEN_CHECK_EN to enforce PKT_LEN-byte packets.
module ts_pkt_scheduler #(
    parameter int CHN_NUM     = 2,
    parameter int CHN_W       = 1,
    parameter int TIMEOUT_CYC = 1024,
    parameter int PKT_LEN     = 188
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CHN_NUM-1:0]   chn_rdy,
    input  logic [CHN_NUM-1:0]   chn_valid,
    input  logic [8*CHN_NUM-1:0] chn_data,
    input  logic [CHN_NUM-1:0]   chn_eop,
    output logic [CHN_NUM-1:0]   chn_ack,
    input  logic                 dn_afull,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic                 out_eop,
    output logic [CHN_W-1:0]     cur_chn,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 len_err
);
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        GRANT = 4'b0010,
        XFER  = 4'b0100,
        GAP   = 4'b1000
    } state_t;

    state_t            state, state_nxt;
    logic [CHN_W-1:0]  last_chn, win, idx;
    logic [7:0]        chn_byte [CHN_NUM];
    logic [15:0]       wd;
    logic              req, sel_valid, sel_eop, byte_ok, wd_fire, eop_out;
    int                sum;

    genvar g;
    generate
        for (g = 0; g < CHN_NUM; g = g + 1) begin : g_byte
            assign chn_byte[g] = chn_data[8*g +: 8];
        end
        if (CHN_NUM < 2 || CHN_NUM > 8 || CHN_W != $clog2(CHN_NUM) ||
            PKT_LEN < 2 || PKT_LEN > 256 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_bad_cfg
            $error("ts_pkt_scheduler: unsupported parameter set");
        end
    endgenerate

    assign sel_valid = chn_valid[cur_chn];
    assign sel_eop   = chn_eop[cur_chn];
    assign byte_ok   = state == XFER && sel_valid;
    assign wd_fire   = state == XFER && !sel_valid && wd == 16'(TIMEOUT_CYC - 1);

`ifdef TS_PKT_LEN_CHECK_EN
    logic [7:0] bcnt;
    logic       at_last;

    // A byte at count PKT_LEN-1 closes the packet whether or not it carries eop.
    assign at_last = bcnt == 8'(PKT_LEN - 1);
    assign eop_out = byte_ok && (sel_eop || at_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt    <= '0;
            len_err <= 1'b0;
        end else begin
            bcnt    <= state == GRANT ? 8'd0 : byte_ok ? bcnt + 8'd1 : bcnt;
            len_err <= byte_ok && (sel_eop ? !at_last : at_last);
        end
    end
`else
    assign eop_out = byte_ok && sel_eop;
    assign len_err = 1'b0;
`endif

    // Walk offsets farthest to nearest so the first requester after last_chn wins.
    always_comb begin
        win = last_chn;
        req = 1'b0;
        idx = '0;
        sum = 0;
        for (int i = CHN_NUM; i >= 1; i--) begin
            sum = int'(last_chn) + i;
            idx = CHN_W'(sum >= CHN_NUM ? sum - CHN_NUM : sum);
            if (chn_rdy[idx]) begin
                win = idx;
                req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = state == GRANT || state == XFER;
        chn_ack   = busy ? (CHN_NUM'(1) << cur_chn) : '0;
        unique case (state)
            IDLE:    state_nxt = req && !dn_afull ? GRANT : IDLE;
            GRANT:   state_nxt = XFER;
            XFER:    state_nxt = eop_out || wd_fire ? GAP : XFER;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_chn     <= '0;
            last_chn    <= CHN_W'(CHN_NUM - 1);
            wd          <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_eop     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE && state_nxt == GRANT) cur_chn <= win;
            if (state == GAP) last_chn <= cur_chn;
            // Watchdog counts idle cycles inside a packet; any other state clears it.
            wd          <= state == XFER && !sel_valid ? wd + 16'd1 : 16'd0;
            out_valid   <= byte_ok;
            out_eop     <= eop_out;
            if (byte_ok) out_data <= chn_byte[cur_chn];
            timeout_err <= wd_fire;
        end
    end
endmodule
